ram_readback_engine: RTL and testbench
======================================

// Module: ram_readback_engine
// PURPOSE
//   Bus master that reads a contiguous RAM address range back out while the CPU is halted.
//   It is the read-side counterpart of the RAM program/data loader.
//   It drives ADDRESS_BUS/RAM_EN/RAM_RW in read mode and streams each word out over a valid/ready port.
//   It keeps a running 16-bit checksum so benches and debug logic can confirm a loaded image.
// PARAMETERS
//   ADDRESS_WIDTH  16  RAM address width
//   DATA_WIDTH     16  RAM word width
//   READ_LATENCY   1   cycles from address+RAM_EN to RAM_DATA valid (legal range 1..7)
// PORTS
//   CLK          in   1   system clock, rising edge
//   RESET        in   1   synchronous, active-low reset
//   HALT         in   1   1 = CPU halted, bus free; engine may own the bus only while HALT=1
//   START        in   1   one-cycle pulse; starts a dump (accepted only in IDLE with HALT=1)
//   START_ADDR   in   AW  first address (sampled on accepted START)
//   END_ADDR     in   AW  last address, inclusive (sampled on accepted START)
//   RAM_EN       out  1   RAM enable
//   RAM_RW       out  1   1 = read; this block never writes
//   ADDRESS_BUS  out  AW  RAM address
//   RAM_DATA     in   DW  RAM read data
//   WORD_VALID   out  1   WORD_DATA/WORD_ADDR valid
//   WORD_READY   in   1   sink accepts the word when VALID&READY on a rising edge
//   WORD_DATA    out  DW  captured word
//   WORD_ADDR    out  AW  address of WORD_DATA
//   BUSY         out  1   engine owns the bus (any state except IDLE)
//   DONE         out  1   one-cycle pulse after the last word is accepted
//   ERROR        out  1   one-cycle pulse: START rejected (START_ADDR>END_ADDR) or aborted by HALT=0
//   CHECKSUM     out  DW  wrapping sum of all words accepted since the last accepted START
// BEHAVIOUR
//   Reset (RESET=0 at posedge, any state): state=IDLE, RAM_EN=0, RAM_RW=1, ADDRESS_BUS=0,
//     WORD_VALID=0, WORD_DATA=0, WORD_ADDR=0, BUSY=0, DONE=0, ERROR=0, CHECKSUM=0.
//   IDLE: bus outputs are at their reset values. START && HALT && START_ADDR<=END_ADDR ->
//     latch range, clear CHECKSUM, cur=START_ADDR, go to ISSUE.
//     START with START_ADDR>END_ADDR -> ERROR pulse, stay in IDLE. START with HALT=0 -> ignored.
//   ISSUE (1 cycle): ADDRESS_BUS=cur, RAM_EN=1, RAM_RW=1; load latency counter=READ_LATENCY-1; go to WAIT.
//   WAIT: hold ADDRESS_BUS/RAM_EN; count down. At counter==0, capture RAM_DATA->WORD_DATA and
//     cur->WORD_ADDR, drop RAM_EN, go to HOLD. READ_LATENCY=1 means RAM_DATA is captured the edge after ISSUE.
//   HOLD: WORD_VALID=1; WORD_DATA/WORD_ADDR stay stable until accepted.
//     On VALID&READY: CHECKSUM+=WORD_DATA (mod 2^DW), WORD_VALID=0.
//       If cur==END_ADDR -> DONE pulse next cycle, go to IDLE. Otherwise cur+=1 and go to ISSUE.
//   Throughput with READY held high: one word every READ_LATENCY+2 cycles.
//   Latency: START edge to first WORD_VALID is READ_LATENCY+1 cycles.
//   Address compare uses AW+1 bits. END_ADDR=all-ones terminates after that word; cur never wraps to 0.
//   START while BUSY is ignored. Range START_ADDR==END_ADDR gives exactly one word.
//   Abort: HALT=0 sampled in ISSUE, WAIT or HOLD -> next cycle IDLE, RAM_EN=0, WORD_VALID=0,
//     ERROR pulse, no DONE. CHECKSUM keeps the partial sum.
//   Never drives RAM_RW=0. DONE and ERROR are never asserted in the same cycle.
// TESTING
//   1 RAM[10..12]=5,0,1, latency 1, READY=1, START 0x0010..0x0012 -> words (10,5),(11,0),(12,1);
//     WORD_VALID first seen 2 cycles after START; DONE pulse; CHECKSUM=0x0006.
//   2 Same range, READY low for 3 cycles on each word -> WORD_DATA/WORD_ADDR stable while VALID=1;
//     no word lost or duplicated; CHECKSUM=0x0006.
//   3 START_ADDR=0x0012, END_ADDR=0x0010 -> ERROR pulse, BUSY stays 0, RAM_EN stays 0.
//   4 RAM[FFFE]=0xFFFF, RAM[FFFF]=0x0002, range FFFE..FFFF -> 2 words, CHECKSUM=0x0001 (wrap);
//     DONE pulse; address 0x0000 is never issued.
//   5 Dump 0x0000..0x000E, drop HALT after the 4th word is accepted -> ERROR, no DONE,
//     RAM_EN=0 next cycle, CHECKSUM = sum of the first 4 words.
//   6 RESET=0 while in WAIT -> all outputs at reset values next edge; a fresh START afterwards
//     dumps correctly; repeat test 1 with READ_LATENCY=3 -> one word every 5 cycles.

Source files
------------

// File: rtl/ram_readback_engine_if.sv
// Bundle of the readback engine's control, RAM bus and word-stream signals.
// The master modport is the engine's side of the bundle.
// The slave modport is the side of the surrounding system: CPU control, RAM and sink.
interface ram_readback_engine_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
);
    // control
    logic                     halt;
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] start_addr;
    logic [ADDRESS_WIDTH-1:0] end_addr;

    // RAM bus
    logic                     ram_en;
    logic                     ram_rw;
    logic [ADDRESS_WIDTH-1:0] address_bus;
    logic [DATA_WIDTH-1:0]    ram_data;

    // word stream
    logic                     word_valid;
    logic                     word_ready;
    logic [DATA_WIDTH-1:0]    word_data;
    logic [ADDRESS_WIDTH-1:0] word_addr;

    // status
    logic                     busy;
    logic                     done;
    logic                     error;
    logic [DATA_WIDTH-1:0]    checksum;

    modport master (
        input  halt, start, start_addr, end_addr, ram_data, word_ready,
        output ram_en, ram_rw, address_bus, word_valid, word_data, word_addr,
               busy, done, error, checksum
    );

    modport slave (
        output halt, start, start_addr, end_addr, ram_data, word_ready,
        input  ram_en, ram_rw, address_bus, word_valid, word_data, word_addr,
               busy, done, error, checksum
    );
endinterface

// File: rtl/ram_readback_engine.sv
// Reads a contiguous RAM range back out while the CPU is halted.
// Each word is fetched with a fixed read latency and presented on a valid/ready stream.
// A running wrapping checksum of the accepted words is kept.
// Supported READ_LATENCY range is 1..7, which is why the latency counter is 3 bits wide.
module ram_readback_engine #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int READ_LATENCY  = 1
) (
    input  logic clk,
    input  logic reset,
    ram_readback_engine_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    state_t                   state_reg;
    // Current and end addresses carry one extra bit so the end compare never aliases on wrap.
    logic [ADDRESS_WIDTH:0]   cur_reg;
    logic [ADDRESS_WIDTH:0]   end_reg;
    logic [ADDRESS_WIDTH:0]   cur_next;
    logic [2:0]               lat_cnt_reg;

    logic                     ram_en_reg;
    logic [ADDRESS_WIDTH-1:0] address_reg;
    logic                     word_valid_reg;
    logic [DATA_WIDTH-1:0]    word_data_reg;
    logic [ADDRESS_WIDTH-1:0] word_addr_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     error_reg;
    logic [DATA_WIDTH-1:0]    checksum_reg;

    logic                     abort;
    logic                     range_ok;
    logic                     last_word;

    // Losing HALT while owning the bus ends the dump immediately.
    assign abort     = (state_reg != S_IDLE) && !bus.halt;
    assign range_ok  = (bus.start_addr <= bus.end_addr);
    assign last_word = (cur_reg == end_reg);
    assign cur_next  = cur_reg + (ADDRESS_WIDTH + 1)'(1);

    // Whole engine: state, bus drive, word capture and checksum, all registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            cur_reg        <= '0;
            end_reg        <= '0;
            lat_cnt_reg    <= '0;
            ram_en_reg     <= 1'b0;
            address_reg    <= '0;
            word_valid_reg <= 1'b0;
            word_data_reg  <= '0;
            word_addr_reg  <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            checksum_reg   <= '0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            if (abort) begin
                // Partial checksum is kept so the caller can see how far the dump got.
                state_reg      <= S_IDLE;
                ram_en_reg     <= 1'b0;
                address_reg    <= '0;
                word_valid_reg <= 1'b0;
                busy_reg       <= 1'b0;
                error_reg      <= 1'b1;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.start && bus.halt) begin
                            if (range_ok) begin
                                cur_reg      <= {1'b0, bus.start_addr};
                                end_reg      <= {1'b0, bus.end_addr};
                                checksum_reg <= '0;
                                address_reg  <= bus.start_addr;
                                ram_en_reg   <= 1'b1;
                                busy_reg     <= 1'b1;
                                state_reg    <= S_ISSUE;
                            end else begin
                                error_reg <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        lat_cnt_reg <= LAT_LOAD;
                        state_reg   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (lat_cnt_reg == 3'd0) begin
                            word_data_reg  <= bus.ram_data;
                            word_addr_reg  <= cur_reg[ADDRESS_WIDTH-1:0];
                            word_valid_reg <= 1'b1;
                            ram_en_reg     <= 1'b0;
                            state_reg      <= S_HOLD;
                        end else begin
                            lat_cnt_reg <= lat_cnt_reg - 3'd1;
                        end
                    end
                    S_HOLD: begin
                        if (word_valid_reg && bus.word_ready) begin
                            checksum_reg   <= checksum_reg + word_data_reg;
                            word_valid_reg <= 1'b0;
                            if (last_word) begin
                                // Stop on the end address itself; the increment is never taken here.
                                done_reg    <= 1'b1;
                                busy_reg    <= 1'b0;
                                address_reg <= '0;
                                state_reg   <= S_IDLE;
                            end else begin
                                cur_reg     <= cur_next;
                                address_reg <= cur_next[ADDRESS_WIDTH-1:0];
                                ram_en_reg  <= 1'b1;
                                state_reg   <= S_ISSUE;
                            end
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ram_en      = ram_en_reg;
    assign bus.ram_rw      = 1'b1;
    assign bus.address_bus = address_reg;
    assign bus.word_valid  = word_valid_reg;
    assign bus.word_data   = word_data_reg;
    assign bus.word_addr   = word_addr_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.error       = error_reg;
    assign bus.checksum    = checksum_reg;
endmodule

// File: tb/tb_ram_readback_engine.sv
// Directed bench for ram_readback_engine: one instance at latency 1, one at latency 3.
module tb_ram_readback_engine;
    logic        clk;
    logic        reset;
    logic        sel;
    logic        start;
    logic        halt;
    logic        word_ready;
    logic [15:0] start_addr;
    logic [15:0] end_addr;

    int checks;
    int failures;

    ram_readback_engine_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) if1 ();
    ram_readback_engine_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) if3 ();

    ram_readback_engine #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.master));
    ram_readback_engine #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .bus(if3.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign if1.halt       = halt;
    assign if3.halt       = halt;
    assign if1.start      = start & ~sel;
    assign if3.start      = start & sel;
    assign if1.start_addr = start_addr;
    assign if3.start_addr = start_addr;
    assign if1.end_addr   = end_addr;
    assign if3.end_addr   = end_addr;
    assign if1.word_ready = word_ready;
    assign if3.word_ready = word_ready;

    // RAM models: data appears READ_LATENCY edges after address+enable, garbage otherwise.
    logic [15:0] mem [0:65535];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [0:2];
    always @(posedge clk) begin
        pipe1    <= if1.ram_en ? mem[if1.address_bus] : 16'hDEAD;
        pipe3[0] <= if3.ram_en ? mem[if3.address_bus] : 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign if1.ram_data = pipe1;
    assign if3.ram_data = pipe3[2];

    // Observed outputs of the selected instance.
    logic        o_ram_en, o_ram_rw, o_valid, o_busy, o_done, o_error;
    logic [15:0] o_address, o_data, o_addr, o_checksum;
    assign o_ram_en   = sel ? if3.ram_en      : if1.ram_en;
    assign o_ram_rw   = sel ? if3.ram_rw      : if1.ram_rw;
    assign o_address  = sel ? if3.address_bus : if1.address_bus;
    assign o_valid    = sel ? if3.word_valid  : if1.word_valid;
    assign o_data     = sel ? if3.word_data   : if1.word_data;
    assign o_addr     = sel ? if3.word_addr   : if1.word_addr;
    assign o_busy     = sel ? if3.busy        : if1.busy;
    assign o_done     = sel ? if3.done        : if1.done;
    assign o_error    = sel ? if3.error       : if1.error;
    assign o_checksum = sel ? if3.checksum    : if1.checksum;

    // Results of the last dump.
    int          n_words, done_cnt, done_cyc, err_cnt, err_cyc, first_valid;
    logic [15:0] got_a [0:31];
    logic [15:0] got_d [0:31];
    int          vcyc  [0:31];
    bit          busy_seen, ramen_seen, addr0_seen, rw0_seen, ramen_at_err, valid_at_err, stable_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse START for range s..e and watch max_cyc cycles after the START edge.
    // stall: cycles READY is held low on each word; abort_after: drop HALT after that many accepts.
    task automatic dump(input logic [15:0] s, input logic [15:0] e, input int stall,
                        input int abort_after, input int max_cyc);
        int          wait_cnt;
        int          nacc;
        bit          holding;
        bit          abort_pending;
        logic [15:0] hold_d;
        logic [15:0] hold_a;
        n_words = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1; first_valid = -1;
        busy_seen = 0; ramen_seen = 0; addr0_seen = 0; rw0_seen = 0;
        ramen_at_err = 0; valid_at_err = 0; stable_bad = 0;
        holding = 0; abort_pending = 0; wait_cnt = 0; nacc = 0;
        hold_d = '0; hold_a = '0;
        @(negedge clk);
        start_addr = s; end_addr = e; start = 1'b1; word_ready = (stall == 0);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (abort_pending) begin
                halt = 1'b0;
                abort_pending = 0;
            end
            if (o_busy) busy_seen = 1;
            if (o_ram_en) begin
                ramen_seen = 1;
                if (o_address == 16'h0000) addr0_seen = 1;
            end
            if (o_ram_rw !== 1'b1) rw0_seen = 1;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_error) begin
                err_cnt++;
                err_cyc = cyc;
                ramen_at_err = o_ram_en;
                valid_at_err = o_valid;
            end
            if (o_valid) begin
                if (!holding) begin
                    holding = 1; hold_d = o_data; hold_a = o_addr; wait_cnt = 0;
                    if (n_words < 32) vcyc[n_words] = cyc;
                    if (first_valid < 0) first_valid = cyc;
                end else if (o_data !== hold_d || o_addr !== hold_a) begin
                    stable_bad = 1;
                end
                if (wait_cnt >= stall) begin
                    word_ready = 1'b1;
                    if (n_words < 32) begin
                        got_a[n_words] = hold_a;
                        got_d[n_words] = hold_d;
                    end
                    n_words++;
                    nacc++;
                    holding = 0;
                    if (nacc == abort_after) abort_pending = 1;
                end else begin
                    word_ready = 1'b0;
                    wait_cnt++;
                end
            end else if (stall != 0) begin
                word_ready = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        sel = 1'b0; start = 1'b0; halt = 1'b1; word_ready = 1'b0;
        start_addr = '0; end_addr = '0; reset = 1'b0;
        for (int i = 0; i < 15; i++) mem[i] = 16'(16'h1111 * (i + 1));
        mem[16'h0010] = 16'h0005;
        mem[16'h0011] = 16'h0000;
        mem[16'h0012] = 16'h0001;
        mem[16'hFFFE] = 16'hFFFF;
        mem[16'hFFFF] = 16'h0002;
        pipe1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ram_en", 32'(o_ram_en), 0);
        chk("rst_ram_rw", 32'(o_ram_rw), 1);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_checksum", 32'(o_checksum), 0);
        chk("rst_l3_busy", 32'(if3.busy), 0);
        reset = 1'b1;

        // START with HALT=0 is ignored
        halt = 1'b0;
        dump(16'h0010, 16'h0012, 0, 0, 6);
        chk("nohalt_busy", 32'(busy_seen), 0);
        chk("nohalt_error", 32'(err_cnt), 0);
        chk("nohalt_words", 32'(n_words), 0);
        halt = 1'b1;

        // Test 1: latency 1, READY=1
        dump(16'h0010, 16'h0012, 0, 0, 14);
        chk("t1_words", 32'(n_words), 3);
        chk("t1_w0", {got_a[0], got_d[0]}, {16'h0010, 16'h0005});
        chk("t1_w1", {got_a[1], got_d[1]}, {16'h0011, 16'h0000});
        chk("t1_w2", {got_a[2], got_d[2]}, {16'h0012, 16'h0001});
        chk("t1_first_valid", 32'(first_valid), 2);
        chk("t1_period", 32'(vcyc[2] - vcyc[1]), 3);
        chk("t1_done_cnt", 32'(done_cnt), 1);
        chk("t1_done_cyc", 32'(done_cyc), 9);
        chk("t1_error", 32'(err_cnt), 0);
        chk("t1_checksum", 32'(o_checksum), 16'h0006);
        chk("t1_busy_end", 32'(o_busy), 0);
        chk("t1_rw", 32'(rw0_seen), 0);

        // Test 2: READY low for 3 cycles on each word
        dump(16'h0010, 16'h0012, 3, 0, 30);
        chk("t2_words", 32'(n_words), 3);
        chk("t2_stable", 32'(stable_bad), 0);
        chk("t2_w0", {got_a[0], got_d[0]}, {16'h0010, 16'h0005});
        chk("t2_w1", {got_a[1], got_d[1]}, {16'h0011, 16'h0000});
        chk("t2_w2", {got_a[2], got_d[2]}, {16'h0012, 16'h0001});
        chk("t2_done_cnt", 32'(done_cnt), 1);
        chk("t2_checksum", 32'(o_checksum), 16'h0006);

        // Test 3: reversed range
        dump(16'h0012, 16'h0010, 0, 0, 5);
        chk("t3_err_cnt", 32'(err_cnt), 1);
        chk("t3_err_cyc", 32'(err_cyc), 0);
        chk("t3_busy", 32'(busy_seen), 0);
        chk("t3_ram_en", 32'(ramen_seen), 0);
        chk("t3_done", 32'(done_cnt), 0);

        // Test 4: top of address space, checksum wraps
        dump(16'hFFFE, 16'hFFFF, 0, 0, 14);
        chk("t4_words", 32'(n_words), 2);
        chk("t4_w0", {got_a[0], got_d[0]}, {16'hFFFE, 16'hFFFF});
        chk("t4_w1", {got_a[1], got_d[1]}, {16'hFFFF, 16'h0002});
        chk("t4_checksum", 32'(o_checksum), 16'h0001);
        chk("t4_done_cnt", 32'(done_cnt), 1);
        chk("t4_addr0", 32'(addr0_seen), 0);

        // Test 5: abort by HALT=0 after the 4th word
        dump(16'h0000, 16'h000E, 0, 4, 20);
        halt = 1'b1;
        chk("t5_words", 32'(n_words), 4);
        chk("t5_err_cnt", 32'(err_cnt), 1);
        chk("t5_err_cyc", 32'(err_cyc), 13);
        chk("t5_done", 32'(done_cnt), 0);
        chk("t5_ram_en", 32'(ramen_at_err), 0);
        chk("t5_valid", 32'(valid_at_err), 0);
        chk("t5_checksum", 32'(o_checksum), 16'hAAAA);

        // Test 6: reset while in WAIT
        @(negedge clk);
        start_addr = 16'h0010; end_addr = 16'h0012; start = 1'b1; word_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t6_busy_wait", 32'(o_busy), 1);
        chk("t6_ram_en_wait", 32'(o_ram_en), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t6_ram_en", 32'(o_ram_en), 0);
        chk("t6_ram_rw", 32'(o_ram_rw), 1);
        chk("t6_address", 32'(o_address), 0);
        chk("t6_valid", 32'(o_valid), 0);
        chk("t6_wdata", 32'(o_data), 0);
        chk("t6_waddr", 32'(o_addr), 0);
        chk("t6_busy", 32'(o_busy), 0);
        chk("t6_done_err", {o_done, o_error}, 0);
        chk("t6_checksum", 32'(o_checksum), 0);

        dump(16'h0010, 16'h0012, 0, 0, 14);
        chk("t6_words", 32'(n_words), 3);
        chk("t6_w2", {got_a[2], got_d[2]}, {16'h0012, 16'h0001});
        chk("t6_checksum_after", 32'(o_checksum), 16'h0006);

        // Test 6b: latency 3 instance, one word every 5 cycles
        sel = 1'b1;
        dump(16'h0010, 16'h0012, 0, 0, 22);
        chk("l3_words", 32'(n_words), 3);
        chk("l3_w0", {got_a[0], got_d[0]}, {16'h0010, 16'h0005});
        chk("l3_w1", {got_a[1], got_d[1]}, {16'h0011, 16'h0000});
        chk("l3_w2", {got_a[2], got_d[2]}, {16'h0012, 16'h0001});
        chk("l3_first_valid", 32'(first_valid), 4);
        chk("l3_period01", 32'(vcyc[1] - vcyc[0]), 5);
        chk("l3_period12", 32'(vcyc[2] - vcyc[1]), 5);
        chk("l3_done_cyc", 32'(done_cyc), 15);
        chk("l3_checksum", 32'(o_checksum), 16'h0006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
